ps2_link_ctrl: RTL and testbench
================================

# ps2_link_ctrl

Bidirectional PS/2 link controller for the Flounder keyboard port. It owns the open-drain KB_CLK/KB_DATA lines. It receives device frames with full start/parity/stop checking, and sequences host-to-device command transmission (e.g. 0xED LED set, 0xFF reset). It arbitrates the shared two-wire link between the two directions, with device-initiated receive taking priority. It sits between the keyboard connector and the CPU-facing keyboard register/FIFO logic in the CPLD.

## Interface
- INHIBIT_CYCLES, 1000, cycles KB_CLK is held low before a host transmit (≥100 µs at system clock)
- TIMEOUT_CYCLES, 20000, maximum cycles between PS/2 falling edges (or from transmit start to first edge) before the frame is aborted
- CLK  in  1  system clock; single clock domain
- RST  in  1  synchronous, active-high reset
- KB_CLK_IN  in  1  raw PS/2 clock pin level (asynchronous)
- KB_DATA_IN  in  1  raw PS/2 data pin level (asynchronous)
- KB_CLK_OE  out  1  1 = pull KB_CLK low; 0 = release
- KB_DATA_OE  out  1  1 = pull KB_DATA low; 0 = release
- TX_REQ  in  1  single-cycle command request; sampled only while TX_BUSY=0
- TX_BYTE  in  8  command byte, captured with TX_REQ
- TX_BUSY  out  1  command latched and not yet finished
- TX_DONE  out  1  one-cycle pulse: device acknowledged the frame
- TX_ERR  out  1  one-cycle pulse: no ACK or timeout
- RX_VALID  out  1  one-cycle pulse: RX_BYTE updated with a good frame
- RX_BYTE  out  8  last good received byte; held until next good frame
- RX_ERR  out  1  one-cycle pulse: bad start/parity/stop or timeout

## Operation
- KB_CLK_IN and KB_DATA_IN pass through 2-flop synchronizers. A falling edge (fe) is synchronized clock 1 in the previous cycle and 0 now. Data is sampled from synchronized data in the fe cycle.
- States: IDLE, RX, TX_INH, TX_BITS, TX_ACK, TX_REL.
- IDLE:
  - fe with data=0 → RX, bit counter=0.
  - fe with data=1 → ignored.
  - Otherwise, if a command is pending → TX_INH.
  - If fe and a pending command coincide, RX wins.
- RX: the next 8 fe's shift data in LSB first, the 9th is parity, and the 10th is stop.
  - Good frame requires odd parity (data ones + parity bit odd) and stop=1. On a good frame, RX_BYTE is loaded and RX_VALID pulses.
  - Otherwise RX_ERR pulses and RX_BYTE is unchanged.
  - Either way the state returns to IDLE.
- TX_REQ while TX_BUSY=0: TX_BYTE is latched and odd parity is computed. The command stays pending through any RX in progress.
- TX_INH: KB_CLK_OE=1 for INHIBIT_CYCLES cycles. Then KB_DATA_OE=1 (start bit), KB_CLK_OE=0 → TX_BITS.
- TX_BITS: on fe 1–8, KB_DATA_OE=~bit[n−1] (LSB first). On fe 9, KB_DATA_OE=~parity. On fe 10, KB_DATA_OE=0 (stop) → TX_ACK.
- TX_ACK: on the next fe, data=0 is ACK → TX_REL; data=1 → TX_ERR pulse, IDLE.
- TX_REL: wait until both synchronized lines are high, then TX_DONE pulse → IDLE.
- Timeout: an edge-interval counter runs in RX, TX_BITS, TX_ACK, and TX_REL. It is cleared on every fe and on state entry.
  - Reaching TIMEOUT_CYCLES in RX: RX_ERR pulse.
  - Reaching TIMEOUT_CYCLES in any TX state: TX_ERR pulse.
  - In all cases both OEs are released and the state returns to IDLE.
- TX_BUSY falls in the same cycle TX_DONE or TX_ERR pulses. A new TX_REQ is accepted in the next cycle.

## Timing
- Reset values (the cycle after RST is sampled high):
  - KB_CLK_OE=0, KB_DATA_OE=0.
  - TX_BUSY, TX_DONE, TX_ERR, RX_VALID, RX_ERR = 0.
  - RX_BYTE=0x00, state IDLE, pending command cleared.
- Reset mid-frame releases both lines on the next cycle. No pulses are emitted for the aborted frame.
- fe detection latency: 3 cycles from the pin edge.
- OE updates are registered: 1 cycle after the fe detection cycle.
- RX_VALID/RX_ERR assert 1 cycle after the stop-bit fe detection.
- TX_BUSY asserts the cycle after TX_REQ is accepted.
- KB_CLK_OE is high for exactly INHIBIT_CYCLES cycles. KB_DATA_OE rises in the same cycle KB_CLK_OE falls.
- All pulses are exactly one cycle wide. At most one of TX_DONE/TX_ERR per command, and at most one of RX_VALID/RX_ERR per frame.

## Test plan
- Device sends 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, LSB-first data, parity 0, stop) → single RX_VALID pulse, RX_BYTE=0x1C, no RX_ERR.
- Same frame with parity=1, then a second frame with stop=0 → two RX_ERR pulses, RX_BYTE stays 0x1C, no RX_VALID.
- TX_REQ with TX_BYTE=0xED; device model clocks 11 edges and drives ACK=0 → the following all hold:
  - KB_CLK_OE high for INHIBIT_CYCLES.
  - Device samples data 0xED, parity 1, stop 1.
  - TX_DONE pulses once and TX_BUSY drops.
- Repeat 0xED with the device never driving ACK (data=1 on the 11th edge) → TX_ERR pulse, both OEs 0, TX_REQ accepted next cycle.
- TX_REQ(0xF4) asserted mid-RX frame of 0x1C → RX completes with RX_VALID first, then inhibit starts; a second TX_REQ while busy is ignored.
- Device stalls after 4 RX bits → RX_ERR at TIMEOUT_CYCLES after the last fe. Separately, assert RST during TX_BITS → OEs are 0 the next cycle and no TX_DONE/TX_ERR is emitted.

Source files
------------

// File: rtl/ps2_link_ctrl.sv
// ps2_link_ctrl
// Bidirectional PS/2 link controller for the keyboard port. Drives the open-drain
// KB_CLK/KB_DATA lines through output-enables, receives device frames with full
// start/parity/stop checking, and sequences host-to-device command frames. A device
// start bit always wins over a pending host command.
//
// Ports:
//   CLK, RST              system clock, synchronous active-high reset
//   KB_CLK_IN, KB_DATA_IN raw pin levels (asynchronous, synchronized here)
//   KB_CLK_OE, KB_DATA_OE 1 = pull the line low
//   TX_REQ, TX_BYTE       command request (accepted only while TX_BUSY=0)
//   TX_BUSY               command latched and not yet finished
//   TX_DONE, TX_ERR       one-cycle completion pulses for a command
//   RX_VALID, RX_BYTE     one-cycle good-frame pulse, last good byte (held)
//   RX_ERR                one-cycle bad-frame / timeout pulse
module ps2_link_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_CLK_IN,
    input  logic       KB_DATA_IN,
    output logic       KB_CLK_OE,
    output logic       KB_DATA_OE,
    input  logic       TX_REQ,
    input  logic [7:0] TX_BYTE,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    output logic       RX_VALID,
    output logic [7:0] RX_BYTE,
    output logic       RX_ERR
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StTxInh,
        StTxBits,
        StTxAck,
        StTxRel
    } state_e;

    // Synchronizers; reset to the idle-high line level so reset never fakes an edge.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fe;

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              tx_pend_q, tx_pend_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_par_q, tx_par_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic [InhW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_err_q, tx_err_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              timed;
    logic              tmo_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= KB_CLK_IN;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= KB_DATA_IN;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fe = clk_prev_q & ~clk_s2_q;

    assign timed   = (state_q == StRx) || (state_q == StTxBits) ||
                     (state_q == StTxAck) || (state_q == StTxRel);
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        rx_byte_d  = rx_byte_q;
        tx_pend_d  = tx_pend_q;
        tx_byte_d  = tx_byte_q;
        tx_par_d   = tx_par_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        inh_cnt_d  = inh_cnt_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        // Edge-interval timer: idle outside timed states, cleared on every falling edge.
        tmo_d      = (timed && !fe) ? tmo_q + 1'b1 : '0;

        // Pending is only clear outside the TX states, so this never races a completion.
        if (TX_REQ && !tx_pend_q) begin
            tx_pend_d = 1'b1;
            tx_byte_d = TX_BYTE;
            tx_par_d  = ~^TX_BYTE;
        end

        unique case (state_q)
            StIdle: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        state_d   = StRx;
                        bit_cnt_d = 4'd0;
                    end
                end else if (tx_pend_q) begin
                    state_d   = StTxInh;
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = '0;
                end
            end

            StRx: begin
                if (fe) begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_d   = {data_s2_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
                        par_bit_d = data_s2_q;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        // Stop bit: odd parity over data+parity and stop=1.
                        if ((^{shift_q, par_bit_q}) && data_s2_q) begin
                            rx_byte_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    rx_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            StTxInh: begin
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = StTxBits;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            StTxBits: begin
                if (fe) begin
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~tx_byte_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~tx_par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = StTxAck;
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (tmo_hit) begin
                    tx_err_d  = 1'b1;
                    tx_pend_d = 1'b0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            StTxAck: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        state_d = StTxRel;
                    end else begin
                        tx_err_d  = 1'b1;
                        tx_pend_d = 1'b0;
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                        state_d   = StIdle;
                    end
                end else if (tmo_hit) begin
                    tx_err_d  = 1'b1;
                    tx_pend_d = 1'b0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            StTxRel: begin
                if (clk_s2_q && data_s2_q) begin
                    tx_done_d = 1'b1;
                    tx_pend_d = 1'b0;
                    state_d   = StIdle;
                end else if (tmo_hit) begin
                    tx_err_d  = 1'b1;
                    tx_pend_d = 1'b0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            rx_byte_q  <= 8'h00;
            tx_pend_q  <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_par_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            inh_cnt_q  <= '0;
            tmo_q      <= '0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            rx_byte_q  <= rx_byte_d;
            tx_pend_q  <= tx_pend_d;
            tx_byte_q  <= tx_byte_d;
            tx_par_q   <= tx_par_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_q      <= tmo_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign KB_CLK_OE  = clk_oe_q;
    assign KB_DATA_OE = data_oe_q;
    assign TX_BUSY    = tx_pend_q;
    assign TX_DONE    = tx_done_q;
    assign TX_ERR     = tx_err_q;
    assign RX_VALID   = rx_valid_q;
    assign RX_BYTE    = rx_byte_q;
    assign RX_ERR     = rx_err_q;

endmodule

// File: tb/tb_ps2_link_ctrl.sv
// Testbench for ps2_link_ctrl: a device model drives/receives PS/2 frames over
// open-drain pins; expected pulses are queued at stimulus time and a monitor pops
// and compares whenever the DUT emits a pulse.
module tb_ps2_link_ctrl;

    localparam int INH = 20;
    localparam int TMO = 200;
    localparam int H   = 8;

    localparam logic [1:0] KRxValid = 2'd0;
    localparam logic [1:0] KRxErr   = 2'd1;
    localparam logic [1:0] KTxDone  = 2'd2;
    localparam logic [1:0] KTxErr   = 2'd3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       TX_REQ = 1'b0;
    logic [7:0] TX_BYTE = 8'h00;
    logic       KB_CLK_IN, KB_DATA_IN;
    logic       KB_CLK_OE, KB_DATA_OE;
    logic       TX_BUSY, TX_DONE, TX_ERR, RX_VALID, RX_ERR;
    logic [7:0] RX_BYTE;

    // Wired-AND open-drain lines with pull-ups.
    assign KB_CLK_IN  = ~(dev_clk_low | KB_CLK_OE);
    assign KB_DATA_IN = ~(dev_data_low | KB_DATA_OE);

    ps2_link_ctrl #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KB_CLK_IN (KB_CLK_IN),
        .KB_DATA_IN(KB_DATA_IN),
        .KB_CLK_OE (KB_CLK_OE),
        .KB_DATA_OE(KB_DATA_OE),
        .TX_REQ    (TX_REQ),
        .TX_BYTE   (TX_BYTE),
        .TX_BUSY   (TX_BUSY),
        .TX_DONE   (TX_DONE),
        .TX_ERR    (TX_ERR),
        .RX_VALID  (RX_VALID),
        .RX_BYTE   (RX_BYTE),
        .RX_ERR    (RX_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_rx_byte = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         rx_err_cyc = -1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void got_event(logic [1:0] k);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none", k);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k == KRxValid || k == KRxErr) begin
                check("rx_byte", 32'(RX_BYTE), 32'(e.b));
                check("rx_pulse_before_inhibit", 32'(KB_CLK_OE), 32'd0);
            end
        end
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: scoreboard pops and inhibit-window length.
    initial begin : monitor
        int   inh_run;
        logic prev_clk_oe;
        inh_run = 0;
        prev_clk_oe = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (RX_VALID) got_event(KRxValid);
                if (RX_ERR) begin
                    rx_err_cyc = cyc;
                    got_event(KRxErr);
                end
                if (TX_DONE) got_event(KTxDone);
                if (TX_ERR) got_event(KTxErr);
                if (KB_CLK_OE) begin
                    inh_run++;
                end else if (prev_clk_oe) begin
                    check("inhibit_len", 32'(inh_run), 32'(INH));
                    check("start_bit_with_release", 32'(KB_DATA_OE), 32'd1);
                    inh_run = 0;
                end
                prev_clk_oe = KB_CLK_OE;
            end
        end
    end

    // Reference model for one device frame.
    task automatic rx_expect(input logic [7:0] b, input logic par, input logic stp);
        ev_t e;
        if ((($countones(b) + int'(par)) % 2 == 1) && stp) begin
            model_rx_byte = b;
            e.kind = KRxValid;
        end else begin
            e.kind = KRxErr;
        end
        e.b = model_rx_byte;
        exp_q.push_back(e);
    endtask

    task automatic push_kind(input logic [1:0] k);
        ev_t e;
        e.kind = k;
        e.b = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits);
        logic [10:0] f;
        f = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~f[i];
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b1;
            last_fall_cyc = cyc;
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge CLK);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_tx_start(output logic seen);
        int w;
        w = 0;
        while (!(KB_CLK_IN && !KB_DATA_IN) && w < INH + 400) begin
            @(negedge CLK);
            w++;
        end
        seen = (w < INH + 400);
        check("tx_start_seen", 32'(seen), 32'd1);
    endtask

    // Device side of a host-to-device frame; samples on each clock release.
    task automatic dev_receive(input logic ack, input logic [7:0] expb);
        logic [10:0] got;
        logic        seen;
        wait_tx_start(seen);
        if (seen) begin
            got[0] = KB_DATA_IN;
            for (int i = 1; i <= 10; i++) begin
                repeat (H) @(negedge CLK);
                dev_clk_low = 1'b1;
                repeat (H) @(negedge CLK);
                dev_clk_low = 1'b0;
                got[i] = KB_DATA_IN;
            end
            repeat (H / 2) @(negedge CLK);
            if (ack) dev_data_low = 1'b1;
            repeat (H / 2) @(negedge CLK);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge CLK);
            dev_data_low = 1'b0;
            check("dev_start", 32'(got[0]), 32'd0);
            check("dev_data", 32'(got[8:1]), 32'(expb));
            check("dev_parity", 32'(got[9]), ($countones(expb) % 2 == 0) ? 32'd1 : 32'd0);
            check("dev_stop", 32'(got[10]), 32'd1);
        end
    endtask

    task automatic issue_tx(input logic [7:0] b);
        TX_REQ = 1'b1;
        TX_BYTE = b;
        @(negedge CLK);
        TX_REQ = 1'b0;
        check("tx_busy_after_req", 32'(TX_BUSY), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        logic       seen;
        logic       err_seen;
        int         w;
        int         kind;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset_clk_oe", 32'(KB_CLK_OE), 32'd0);
        check("reset_data_oe", 32'(KB_DATA_OE), 32'd0);
        check("reset_busy", 32'(TX_BUSY), 32'd0);
        check("reset_pulses", 32'({TX_DONE, TX_ERR, RX_VALID, RX_ERR}), 32'd0);
        check("reset_rx_byte", 32'(RX_BYTE), 32'h00);
        repeat (5) @(negedge CLK);

        // Directed receive: good 0x1C, then bad parity, then bad stop.
        rx_expect(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        rx_expect(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        rx_expect(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        repeat (10) @(negedge CLK);
        check("rx_byte_held", 32'(RX_BYTE), 32'h1C);

        // Random device frames with occasional parity/stop corruption.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            kind = int'($urandom_range(0, 3));
            if (kind == 1) begin
                rx_expect(b, ($countones(b) % 2 == 1), 1'b1);
                send_frame(b, ($countones(b) % 2 == 1), 1'b1, 11);
            end else if (kind == 2) begin
                rx_expect(b, ($countones(b) % 2 == 0), 1'b0);
                send_frame(b, ($countones(b) % 2 == 0), 1'b0, 11);
            end else begin
                rx_expect(b, ($countones(b) % 2 == 0), 1'b1);
                send_frame(b, ($countones(b) % 2 == 0), 1'b1, 11);
            end
            repeat (int'($urandom_range(2, 20))) @(negedge CLK);
        end

        // Host command 0xED with ACK.
        push_kind(KTxDone);
        issue_tx(8'hED);
        dev_receive(1'b1, 8'hED);
        repeat (10) @(negedge CLK);
        check("busy_after_done", 32'(TX_BUSY), 32'd0);

        // 0xED without ACK, then a new request right after TX_ERR.
        push_kind(KTxErr);
        issue_tx(8'hED);
        b = 8'($urandom);
        fork
            dev_receive(1'b0, 8'hED);
            begin
                w = 0;
                err_seen = 1'b0;
                while (!err_seen && w < 2000) begin
                    @(negedge CLK);
                    w++;
                    err_seen = TX_ERR;
                end
                check("tx_err_seen", 32'(err_seen), 32'd1);
                if (err_seen) begin
                    check("err_clk_oe", 32'(KB_CLK_OE), 32'd0);
                    check("err_data_oe", 32'(KB_DATA_OE), 32'd0);
                    check("err_busy", 32'(TX_BUSY), 32'd0);
                    push_kind(KTxDone);
                    issue_tx(b);
                end
            end
        join
        if (err_seen) dev_receive(1'b1, b);
        repeat (10) @(negedge CLK);

        // Command raised mid-frame; a second request while busy is dropped.
        rx_expect(8'h1C, 1'b0, 1'b1);
        push_kind(KTxDone);
        fork
            send_frame(8'h1C, 1'b0, 1'b1, 11);
            begin
                repeat (10 * H) @(negedge CLK);
                issue_tx(8'hF4);
                repeat (30) @(negedge CLK);
                TX_REQ = 1'b1;
                TX_BYTE = 8'h55;
                @(negedge CLK);
                TX_REQ = 1'b0;
            end
        join
        dev_receive(1'b1, 8'hF4);
        repeat (10) @(negedge CLK);

        // Random host commands.
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            push_kind(KTxDone);
            issue_tx(b);
            dev_receive(1'b1, b);
            repeat (int'($urandom_range(5, 20))) @(negedge CLK);
        end

        // Receive timeout: device stalls after start + 4 data bits.
        rx_err_cyc = -1;
        push_kind(KRxErr);
        exp_q[exp_q.size() - 1].b = model_rx_byte;
        send_frame(8'($urandom), 1'b0, 1'b1, 5);
        w = 0;
        while (rx_err_cyc < last_fall_cyc && w < TMO + 100) begin
            @(negedge CLK);
            w++;
        end
        check("rx_timeout_window",
              32'((rx_err_cyc - last_fall_cyc >= TMO) && (rx_err_cyc - last_fall_cyc <= TMO + 6)),
              32'd1);
        repeat (10) @(negedge CLK);

        // Reset in the middle of the data bits: lines freed, no completion pulse.
        issue_tx(8'($urandom));
        wait_tx_start(seen);
        for (int i = 0; i < 3; i++) begin
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b0;
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_clk_oe", 32'(KB_CLK_OE), 32'd0);
        check("rst_data_oe", 32'(KB_DATA_OE), 32'd0);
        check("rst_busy", 32'(TX_BUSY), 32'd0);
        RST = 1'b0;
        repeat (TMO + 50) @(negedge CLK);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
